// File: rtl/riscv_store_monitor_if.sv
// ============================================================================
//  Module   : riscv_store_monitor_if
//  Brief    : Store-bus and trace-read signal bundle for riscv_store_monitor.
//             The master side is the core/debug reader, the slave side is
//             the monitor itself.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface riscv_store_monitor_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 16
) ();

  localparam int CNT_W = $clog2(DEPTH + 1);

  // Core data-memory write port, observed by the monitor
  logic                  MemWrite;
  logic [ADDR_WIDTH-1:0] DataAddr;
  logic [DATA_WIDTH-1:0] WriteData;

  // Trace FIFO read port (show-ahead head plus pop request)
  logic                  rd_en;
  logic                  trace_valid;
  logic [ADDR_WIDTH-1:0] trace_addr;
  logic [DATA_WIDTH-1:0] trace_data;
  logic [CNT_W-1:0]      trace_count;

  modport master (
    output MemWrite,
    output DataAddr,
    output WriteData,
    output rd_en,
    input  trace_valid,
    input  trace_addr,
    input  trace_data,
    input  trace_count
  );

  modport slave (
    input  MemWrite,
    input  DataAddr,
    input  WriteData,
    input  rd_en,
    output trace_valid,
    output trace_addr,
    output trace_data,
    output trace_count
  );

endinterface

`default_nettype wire

// File: rtl/riscv_store_monitor.sv
// ============================================================================
//  Module   : riscv_store_monitor
//  Brief    : Watches the core's data-memory write port, records every store
//             made while the program is running into a show-ahead trace FIFO,
//             and produces a PASS/FAIL/TIMEOUT verdict from a sentinel store
//             and a cycle budget.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module riscv_store_monitor #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DEPTH          = 16,
  parameter logic [ADDR_WIDTH-1:0] PASS_ADDR      = 100,
  parameter logic [DATA_WIDTH-1:0] PASS_DATA      = 25,
  parameter int                    TIMEOUT_CYCLES = 100000
) (
  input  logic                      clk,
  input  logic                      reset,
  riscv_store_monitor_if.slave      bus,
  output logic                      overflow,
  output logic [15:0]               store_count,
  output logic                      done,
  output logic                      pass,
  output logic                      fail,
  output logic                      timeout
);

  // --------------------------------------------------------------------------
  // Derived sizes and constants
  // --------------------------------------------------------------------------
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;
  // The cycle counter never needs to hold more than TIMEOUT_CYCLES-1
  localparam int CYC_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam bit               C_TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CYC_W-1:0] C_CYC_LAST   =
    CYC_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_DEPTH      = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_CNT_ONE    = CNT_W'(1);
  localparam logic [PTR_W-1:0] C_PTR_ONE    = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_PASS    = 2'd1,
    ST_FAIL    = 2'd2,
    ST_TIMEOUT = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t                state_q,       state_d;
  logic [CYC_W-1:0]      cyc_q,         cyc_d;
  logic [PTR_W-1:0]      wr_ptr_q,      wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q,      rd_ptr_d;
  logic [CNT_W-1:0]      count_q,       count_d;
  logic [ADDR_WIDTH-1:0] head_addr_q,   head_addr_d;
  logic [DATA_WIDTH-1:0] head_data_q,   head_data_d;
  logic                  overflow_q,    overflow_d;
  logic [15:0]           store_count_q, store_count_d;

  // Trace storage; contents are only meaningful between the pointers
  logic [ENT_W-1:0]      mem_q [DEPTH];

  // --------------------------------------------------------------------------
  // Event decode
  // --------------------------------------------------------------------------
  logic             in_run;
  logic             store_seen;
  logic             sentinel;
  logic             pop;
  logic             push;
  logic [ENT_W-1:0] push_entry;
  logic [PTR_W-1:0] rd_ptr_next;
  logic [ENT_W-1:0] next_entry;

  assign in_run      = (state_q == ST_RUN);
  // Only stores made while the program is still running are of interest
  assign store_seen  = in_run && bus.MemWrite;
  assign sentinel    = store_seen && (bus.DataAddr == PASS_ADDR);
  // rd_en on an empty FIFO is not a pop
  assign pop         = bus.rd_en && (count_q != '0);
  // A full FIFO can still accept a store when the head leaves in the same cycle
  assign push        = store_seen && ((count_q != C_DEPTH) || pop);
  assign push_entry  = {bus.DataAddr, bus.WriteData};
  assign rd_ptr_next = rd_ptr_q + C_PTR_ONE;
  assign next_entry  = mem_q[rd_ptr_next];

  // Verdict FSM: leave RUN on the sentinel store, otherwise on budget expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (sentinel) begin
          state_d = (bus.WriteData == PASS_DATA) ? ST_PASS : ST_FAIL;
        end else if (C_TIMEOUT_EN && (cyc_q == C_CYC_LAST)) begin
          state_d = ST_TIMEOUT;
        end
      end
      ST_PASS:    state_d = ST_PASS;
      ST_FAIL:    state_d = ST_FAIL;
      ST_TIMEOUT: state_d = ST_TIMEOUT;
      default:    state_d = ST_RUN;
    endcase
  end

  // RUN-cycle counter; frozen once a verdict has been reached
  always_comb begin
    cyc_d = cyc_q;
    if (in_run && C_TIMEOUT_EN) begin
      cyc_d = cyc_q + CYC_W'(1);
    end
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + C_PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_next;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + C_CNT_ONE;
      2'b01:   count_d = count_q - C_CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Show-ahead head register: tracks the entry that will be at the front
  // after this edge, and keeps its last value once the FIFO drains
  always_comb begin
    head_addr_d = head_addr_q;
    head_data_d = head_data_q;
    if (push && ((count_q == '0) || (pop && (count_q == C_CNT_ONE)))) begin
      // The new store becomes the front entry directly
      {head_addr_d, head_data_d} = push_entry;
    end else if (pop && (count_q > C_CNT_ONE)) begin
      // The entry behind the departing head moves up
      {head_addr_d, head_data_d} = next_entry;
    end
  end

  // Store counter (saturating) and sticky overflow
  always_comb begin
    store_count_d = store_count_q;
    overflow_d    = overflow_q;
    if (store_seen && (store_count_q != 16'hFFFF)) begin
      store_count_d = store_count_q + 16'd1;
    end
    if (store_seen && !push) begin
      overflow_d = 1'b1;
    end
  end

  // Control registers with synchronous reset; reset overrides every event
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      cyc_q         <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      head_addr_q   <= '0;
      head_data_q   <= '0;
      overflow_q    <= 1'b0;
      store_count_q <= '0;
    end else begin
      state_q       <= state_d;
      cyc_q         <= cyc_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      head_addr_q   <= head_addr_d;
      head_data_q   <= head_data_d;
      overflow_q    <= overflow_d;
      store_count_q <= store_count_d;
    end
  end

  // Trace storage write; no reset needed since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wr_ptr_q] <= push_entry;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs: all straight from registers
  // --------------------------------------------------------------------------
  assign bus.trace_valid = (count_q != '0);
  assign bus.trace_addr  = head_addr_q;
  assign bus.trace_data  = head_data_q;
  assign bus.trace_count = count_q;

  assign overflow    = overflow_q;
  assign store_count = store_count_q;
  assign done        = (state_q != ST_RUN);
  assign pass        = (state_q == ST_PASS);
  assign fail        = (state_q == ST_FAIL);
  assign timeout     = (state_q == ST_TIMEOUT);

endmodule

`default_nettype wire

// File: tb/tb_riscv_store_monitor.sv
// ============================================================================
//  Module   : tb_riscv_store_monitor
//  Brief    : Self-checking bench for riscv_store_monitor (DEPTH=4,
//             TIMEOUT_CYCLES=50): vector table, directed corner sequences
//             and randomized traffic against a queue-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_riscv_store_monitor;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam int TMO   = 50;
  localparam int SADDR = 100;
  localparam int SDATA = 25;

  localparam int M_RUN  = 0;
  localparam int M_PASS = 1;
  localparam int M_FAIL = 2;
  localparam int M_TMO  = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        overflow;
  logic [15:0] store_count;
  logic        done, pass, fail, timeout;

  riscv_store_monitor_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) bus ();

  riscv_store_monitor #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .DEPTH          (DEPTH),
    .PASS_ADDR      (32'd100),
    .PASS_DATA      (32'd25),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .overflow    (overflow),
    .store_count (store_count),
    .done        (done),
    .pass        (pass),
    .fail        (fail),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: trace as a queue of {addr,data}, verdict as a small enum
  logic [63:0] m_q [$];
  int          m_state;
  int          m_cycles;
  int          m_sc;
  bit          m_ovf;
  logic [31:0] m_haddr, m_hdata;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic model_step(input bit r, input bit mw, input logic [31:0] a,
                            input logic [31:0] d, input bit rd);
    bit run;
    if (r) begin
      m_q.delete();
      m_state = M_RUN; m_cycles = 0; m_sc = 0; m_ovf = 0;
      m_haddr = 0; m_hdata = 0;
      return;
    end
    run = (m_state == M_RUN);
    if (rd && m_q.size() > 0) void'(m_q.pop_front());
    if (run && mw) begin
      if (m_sc < 65535) m_sc++;
      if (m_q.size() < DEPTH) m_q.push_back({a, d});
      else m_ovf = 1;
    end
    if (run) begin
      m_cycles++;
      if (mw && a == SADDR) m_state = (d == SDATA) ? M_PASS : M_FAIL;
      else if (m_cycles == TMO) m_state = M_TMO;
    end
    if (m_q.size() > 0) begin
      m_haddr = m_q[0][63:32];
      m_hdata = m_q[0][31:0];
    end
  endtask

  task automatic model_compare();
    check("valid",       32'(bus.trace_valid), 32'(m_q.size() != 0));
    check("count",       32'(bus.trace_count), 32'(m_q.size()));
    check("head_addr",   bus.trace_addr,       m_haddr);
    check("head_data",   bus.trace_data,       m_hdata);
    check("store_count", 32'(store_count),     32'(m_sc));
    check("overflow",    32'(overflow),        32'(m_ovf));
    check("pass",        32'(pass),            32'(m_state == M_PASS));
    check("fail",        32'(fail),            32'(m_state == M_FAIL));
    check("timeout",     32'(timeout),         32'(m_state == M_TMO));
    check("done",        32'(done),            32'(m_state != M_RUN));
  endtask

  // One clock: drive inputs, advance model, sample 1ns after the edge
  task automatic step(input bit r, input bit mw, input logic [31:0] a,
                      input logic [31:0] d, input bit rd);
    reset         = r;
    bus.MemWrite  = mw;
    bus.DataAddr  = a;
    bus.WriteData = d;
    bus.rd_en     = rd;
    model_step(r, mw, a, d, rd);
    @(posedge clk);
    #1;
    model_compare();
  endtask

  typedef struct {
    bit rst; bit mw; logic [31:0] a; logic [31:0] d; bit rd;
    int cnt; bit vld; logic [31:0] ea; logic [31:0] ed; int sc;
    bit ovf; bit ps; bit fl; bit to;
  } vec_t;

  function automatic vec_t v(bit rst, bit mw, int a, int d, bit rd, int cnt, bit vld,
                             int ea, int ed, int sc, bit ovf, bit ps, bit fl, bit to);
    vec_t t;
    t.rst = rst; t.mw = mw; t.a = a; t.d = d; t.rd = rd;
    t.cnt = cnt; t.vld = vld; t.ea = ea; t.ed = ed; t.sc = sc;
    t.ovf = ovf; t.ps = ps; t.fl = fl; t.to = to;
    return t;
  endfunction

  vec_t tbl [$];

  initial begin
    reset = 1'b1; bus.MemWrite = 0; bus.DataAddr = 0; bus.WriteData = 0; bus.rd_en = 0;

    // ---------------- vector table ----------------
    //                rst mw  a    d  rd cnt vld ea   ed  sc ovf ps fl to
    tbl.push_back(v(1, 0,   0,  0, 0,  0, 0,   0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1,   4,  7, 0,  1, 1,   4,  7, 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1,   8,  9, 0,  2, 1,   4,  7, 2, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 100, 25, 0,  3, 1,   4,  7, 3, 0, 1, 0, 0));
    tbl.push_back(v(0, 0,   0,  0, 1,  2, 1,   8,  9, 3, 0, 1, 0, 0));
    tbl.push_back(v(0, 0,   0,  0, 1,  1, 1, 100, 25, 3, 0, 1, 0, 0));
    tbl.push_back(v(0, 0,   0,  0, 1,  0, 0, 100, 25, 3, 0, 1, 0, 0));
    tbl.push_back(v(0, 1,   5,  5, 0,  0, 0, 100, 25, 3, 0, 1, 0, 0));
    tbl.push_back(v(0, 0,   0,  0, 1,  0, 0, 100, 25, 3, 0, 1, 0, 0));
    tbl.push_back(v(1, 1, 100, 24, 0,  0, 0,   0,  0, 0, 0, 0, 0, 0));
    tbl.push_back(v(0, 1, 100, 24, 0,  1, 1, 100, 24, 1, 0, 0, 1, 0));
    tbl.push_back(v(0, 1, 200,  1, 0,  1, 1, 100, 24, 1, 0, 0, 1, 0));
    tbl.push_back(v(1, 0,   0,  0, 0,  0, 0,   0,  0, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 6; k++)
      tbl.push_back(v(0, 1, k, k, 0, (k < 4) ? k : 4, 1, 1, 1, k, k > 4, 0, 0, 0));
    tbl.push_back(v(0, 0,   0,  0, 1,  3, 1,   2,  2, 6, 1, 0, 0, 0));
    tbl.push_back(v(0, 0,   0,  0, 1,  2, 1,   3,  3, 6, 1, 0, 0, 0));
    tbl.push_back(v(0, 0,   0,  0, 1,  1, 1,   4,  4, 6, 1, 0, 0, 0));
    tbl.push_back(v(0, 0,   0,  0, 1,  0, 0,   4,  4, 6, 1, 0, 0, 0));
    tbl.push_back(v(1, 0,   0,  0, 0,  0, 0,   0,  0, 0, 0, 0, 0, 0));
    for (int j = 0; j < 4; j++)
      tbl.push_back(v(0, 1, 10 + j, j + 1, 0, j + 1, 1, 10, 1, j + 1, 0, 0, 0, 0));
    tbl.push_back(v(0, 1,  14,  5, 1,  4, 1,  11,  2, 5, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,   0,  0, 1,  3, 1,  12,  3, 5, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,   0,  0, 1,  2, 1,  13,  4, 5, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,   0,  0, 1,  1, 1,  14,  5, 5, 0, 0, 0, 0));
    tbl.push_back(v(0, 0,   0,  0, 1,  0, 0,  14,  5, 5, 0, 0, 0, 0));
    tbl.push_back(v(0, 1,  20,  6, 1,  1, 1,  20,  6, 6, 0, 0, 0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].mw, tbl[i].a, tbl[i].d, tbl[i].rd);
      check($sformatf("tbl%0d_count", i), 32'(bus.trace_count), 32'(tbl[i].cnt));
      check($sformatf("tbl%0d_valid", i), 32'(bus.trace_valid), 32'(tbl[i].vld));
      check($sformatf("tbl%0d_addr", i),  bus.trace_addr,       tbl[i].ea);
      check($sformatf("tbl%0d_data", i),  bus.trace_data,       tbl[i].ed);
      check($sformatf("tbl%0d_sc", i),    32'(store_count),     32'(tbl[i].sc));
      check($sformatf("tbl%0d_ovf", i),   32'(overflow),        32'(tbl[i].ovf));
      check($sformatf("tbl%0d_pass", i),  32'(pass),            32'(tbl[i].ps));
      check($sformatf("tbl%0d_fail", i),  32'(fail),            32'(tbl[i].fl));
      check($sformatf("tbl%0d_tmo", i),   32'(timeout),         32'(tbl[i].to));
      check($sformatf("tbl%0d_done", i),  32'(done),            32'(tbl[i].ps | tbl[i].fl | tbl[i].to));
    end

    // ---------------- timeout after 50 RUN cycles ----------------
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < TMO - 1; c++) step(0, 0, 0, 0, 0);
    check("tmo_before", 32'(timeout), 32'd0);
    step(0, 0, 0, 0, 0);
    check("tmo_after",      32'(timeout), 32'd1);
    check("tmo_done",       32'(done),    32'd1);
    step(0, 1, 3, 3, 0);
    check("tmo_store_ign",  32'(store_count), 32'd0);

    // ---------------- sentinel on the 50th cycle beats timeout ----------------
    step(1, 0, 0, 0, 0);
    for (int c = 0; c < TMO - 1; c++) step(0, 0, 0, 0, 0);
    step(0, 1, SADDR, SDATA, 0);
    check("race_pass", 32'(pass),    32'd1);
    check("race_tmo",  32'(timeout), 32'd0);
    for (int c = 0; c < 3; c++) step(0, 0, 0, 0, 0);
    check("race_tmo_late", 32'(timeout), 32'd0);

    // ---------------- reset mid-run with entries and overflow ----------------
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) step(0, 1, k, k, 0);
    step(0, 0, 0, 0, 1);
    check("mid_count", 32'(bus.trace_count), 32'd3);
    check("mid_ovf",   32'(overflow),        32'd1);
    step(1, 1, 9, 9, 1);
    check("mid_rst_count", 32'(bus.trace_count), 32'd0);
    check("mid_rst_ovf",   32'(overflow),        32'd0);
    check("mid_rst_sc",    32'(store_count),     32'd0);
    check("mid_rst_addr",  bus.trace_addr,       32'd0);
    step(0, 1, 7, 8, 0);
    check("mid_fresh_count", 32'(bus.trace_count), 32'd1);
    check("mid_fresh_head",  bus.trace_data,       32'd8);

    // ---------------- randomized traffic vs. model ----------------
    for (int run = 0; run < 20; run++) begin
      step(1, 0, 0, 0, 0);
      for (int c = 0; c < 80; c++) begin
        bit          r, mw, rd;
        logic [31:0] a, d;
        r  = ($urandom_range(0, 59) == 0);
        mw = $urandom_range(0, 1);
        rd = ($urandom_range(0, 9) < 4);
        if ($urandom_range(0, 23) == 0) begin
          a = SADDR;
          d = $urandom_range(0, 1) ? SDATA : $urandom_range(0, 40);
        end else begin
          a = $urandom_range(0, 255);
          if (a == SADDR) a = a + 1;
          d = $urandom;
        end
        step(r, mw, a, d, rd);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
